// File: rtl/sha_job_scheduler.sv
// Descriptor FIFO plus launch/run/complete sequencer for a single SHA worker.
// Optional watchdog: define JOB_TIMEOUT_EN to abort jobs that exceed TIMEOUT_CYCLES.
module sha_job_scheduler #(
  parameter int DEPTH          = 4,
  parameter int ID_WID         = 4,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sub_valid,
  output logic                   sub_ready,
  input  logic [63:0]            sub_read_base,
  input  logic [63:0]            sub_write_base,
  input  logic [63:0]            sub_num,
  input  logic [63:0]            sub_size,
  output logic [ID_WID-1:0]      sub_id,
  output logic                   wk_rst,
  output logic                   wk_start,
  output logic [63:0]            wk_read_base,
  output logic [63:0]            wk_write_base,
  output logic [63:0]            wk_num_read,
  output logic [63:0]            wk_read_size,
  input  logic                   wk_done,
  input  logic [31:0]            wk_retval,
  output logic                   cpl_valid,
  input  logic                   cpl_ready,
  output logic [ID_WID-1:0]      cpl_id,
  output logic [31:0]            cpl_retval,
  output logic [31:0]            cpl_cycles,
  output logic                   cpl_status,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_level,
  output logic [2:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Handshakes: a descriptor transfers on a rising clk edge where sub_valid && sub_ready;
  // a completion record transfers on an edge where cpl_valid && cpl_ready.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RESET_WK = 3'd1,
    S_LAUNCH   = 3'd2,
    S_RUN      = 3'd3,
    S_COMPLETE = 3'd4
  } state_e;

  typedef struct packed {
    logic [63:0]       rb;
    logic [63:0]       wb;
    logic [63:0]       num;
    logic [63:0]       size;
    logic [ID_WID-1:0] id;
  } desc_t;

  state_e state_q, state_d;

  desc_t             fifo_mem [DEPTH];
  desc_t             head;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic [ID_WID-1:0] next_id_q, next_id_d;
  logic              push, pop;

  logic [63:0]       rb_q, rb_d, wb_q, wb_d, num_q, num_d, size_q, size_d;
  logic [ID_WID-1:0] job_id_q, job_id_d, cpl_id_q, cpl_id_d;
  logic [31:0]       rst_cnt_q, rst_cnt_d, cyc_q, cyc_d;
  logic [31:0]       ret_q, ret_d, cycles_q, cycles_d;
  logic              timeout_hit;

  // sub_ready looks only at registered occupancy; a same-cycle pop does not raise it.
  assign sub_ready   = !reset && (count_q != FULL);
  assign sub_id      = next_id_q;
  assign queue_level = count_q;
  assign push        = sub_valid && sub_ready;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign head        = fifo_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    next_id_d = next_id_q;
    if (push) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      next_id_d = next_id_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      next_id_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      next_id_q <= next_id_d;
    end
  end

  // Storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {sub_read_base, sub_write_base, sub_num, sub_size, next_id_q};
  end

`ifdef JOB_TIMEOUT_EN
  logic status_q, status_d;

  assign timeout_hit = (cyc_q == 32'(TIMEOUT_CYCLES));
  assign cpl_status  = status_q;

  always_comb begin
    status_d = status_q;
    if (state_q == S_RUN) begin
      if (wk_done)          status_d = 1'b0;
      else if (timeout_hit) status_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) status_q <= 1'b0;
    else       status_q <= status_d;
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^(32'(TIMEOUT_CYCLES));
  assign timeout_hit    = 1'b0;
  assign cpl_status     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The pop cycle already counts as the first wk_rst cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (count_q != '0) state_d = (RST_CYCLES > 1) ? S_RESET_WK : S_LAUNCH;
      S_RESET_WK: if (rst_cnt_q >= 32'(RST_CYCLES - 1)) state_d = S_LAUNCH;
      S_LAUNCH:   state_d = S_RUN;
      S_RUN:      if (wk_done || timeout_hit) state_d = S_COMPLETE;
      S_COMPLETE: if (cpl_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // A timed-out job keeps the worker in reset while its record waits for the host.
  always_comb begin
    wk_rst    = 1'b0;
    wk_start  = 1'b0;
    cpl_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        wk_rst = 1'b1;
        busy   = 1'b0;
      end
      S_RESET_WK: wk_rst = 1'b1;
      S_LAUNCH:   wk_start = 1'b1;
      S_RUN:      wk_rst = 1'b0;
      S_COMPLETE: begin
        cpl_valid = 1'b1;
        wk_rst    = cpl_status;
      end
      default: begin
        wk_rst = 1'b1;
        busy   = 1'b0;
      end
    endcase
  end

  assign dbg_state = state_q;

  always_comb begin
    rb_d      = rb_q;
    wb_d      = wb_q;
    num_d     = num_q;
    size_d    = size_q;
    job_id_d  = job_id_q;
    rst_cnt_d = rst_cnt_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    cycles_d  = cycles_q;
    cpl_id_d  = cpl_id_q;
    if (pop) begin
      rb_d      = head.rb;
      wb_d      = head.wb;
      num_d     = head.num;
      size_d    = head.size;
      job_id_d  = head.id;
      rst_cnt_d = 32'd1;
    end
    if (state_q == S_RESET_WK) rst_cnt_d = rst_cnt_q + 32'd1;
    if (state_q == S_LAUNCH)   cyc_d = 32'd1;
    if (state_q == S_RUN) begin
      if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
      if (wk_done) begin
        ret_d    = wk_retval;
        cycles_d = cyc_q;
        cpl_id_d = job_id_q;
      end else if (timeout_hit) begin
        ret_d    = 32'd0;
        cycles_d = 32'(TIMEOUT_CYCLES);
        cpl_id_d = job_id_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_q      <= '0;
      wb_q      <= '0;
      num_q     <= '0;
      size_q    <= '0;
      job_id_q  <= '0;
      rst_cnt_q <= '0;
      cyc_q     <= '0;
      ret_q     <= '0;
      cycles_q  <= '0;
      cpl_id_q  <= '0;
    end else begin
      rb_q      <= rb_d;
      wb_q      <= wb_d;
      num_q     <= num_d;
      size_q    <= size_d;
      job_id_q  <= job_id_d;
      rst_cnt_q <= rst_cnt_d;
      cyc_q     <= cyc_d;
      ret_q     <= ret_d;
      cycles_q  <= cycles_d;
      cpl_id_q  <= cpl_id_d;
    end
  end

  assign wk_read_base  = rb_q;
  assign wk_write_base = wb_q;
  assign wk_num_read   = num_q;
  assign wk_read_size  = size_q;
  assign cpl_id        = cpl_id_q;
  assign cpl_retval    = ret_q;
  assign cpl_cycles    = cycles_q;

endmodule
